// File: rtl/game_slow_timer.sv
// game_slow_timer: responder side of the game FSM's timed-wait handshake.
// A requestTime strobe loads a tick count; frame ticks (clk / TICK_DIV) count it
// down and a single-cycle slowClk pulse reports expiry. Supports pause, cancel
// and retrigger.
module game_slow_timer #(
    parameter int unsigned TICK_DIV = 525000,
    parameter int unsigned REQ_W    = 11
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             requestTime,
    input  logic [REQ_W-1:0] slowClkRequest,
    input  logic             pauseTimer,
    input  logic             cancel,
    output logic             slowClk,
    output logic             busy,
    output logic             tickPulse,
    output logic [REQ_W-1:0] ticksRemaining
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           r_state;
    state_e           w_state_d;
    logic [PW-1:0]    r_presc;
    logic [PW-1:0]    w_presc_d;
    logic [REQ_W-1:0] r_remaining;
    logic [REQ_W-1:0] w_remaining_d;
    logic             r_tick_pulse;
    logic             w_tick_pulse_d;
    logic             r_slow_clk;
    logic             r_busy;

    // State, counters and registered outputs; reset drops everything to idle.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state      <= StIdle;
            r_presc      <= '0;
            r_remaining  <= '0;
            r_tick_pulse <= 1'b0;
            r_slow_clk   <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_d;
            r_presc      <= w_presc_d;
            r_remaining  <= w_remaining_d;
            r_tick_pulse <= w_tick_pulse_d;
            // Outputs track the next state so they line up with r_state.
            r_slow_clk   <= (w_state_d == StDone);
            r_busy       <= (w_state_d == StRun);
        end
    end

    // Next-state: cancel beats requestTime, which beats the tick/expiry path.
    always_comb begin
        w_state_d      = r_state;
        w_presc_d      = r_presc;
        w_remaining_d  = r_remaining;
        w_tick_pulse_d = 1'b0;

        if (cancel && (r_state != StIdle)) begin
            // A pulse already showing in DONE still completes; only the wait is dropped.
            w_state_d     = StIdle;
            w_presc_d     = '0;
            w_remaining_d = '0;
        end else if (requestTime) begin
            w_presc_d = '0;
            if (slowClkRequest != '0) begin
                w_state_d     = StRun;
                w_remaining_d = slowClkRequest;
            end else begin
                w_state_d     = StDone;
                w_remaining_d = '0;
            end
        end else begin
            case (r_state)
                StRun: begin
                    if (!pauseTimer) begin
                        if (r_presc == PRESC_LAST) begin
                            w_presc_d      = '0;
                            w_tick_pulse_d = 1'b1;
                            if (r_remaining <= REQ_W'(1)) begin
                                w_state_d     = StDone;
                                w_remaining_d = '0;
                            end else begin
                                w_remaining_d = r_remaining - REQ_W'(1);
                            end
                        end else begin
                            w_presc_d = r_presc + PW'(1);
                        end
                    end
                end
                StDone:  w_state_d = StIdle;
                default: w_state_d = StIdle;
            endcase
        end
    end

    assign slowClk        = r_slow_clk;
    assign busy           = r_busy;
    assign tickPulse      = r_tick_pulse;
    assign ticksRemaining = r_remaining;

endmodule

// File: tb/tb_game_slow_timer.sv
// Directed bench for game_slow_timer with TICK_DIV=4.
module tb_game_slow_timer;

    localparam int unsigned TICK_DIV = 4;
    localparam int unsigned REQ_W    = 11;

    logic             clk;
    logic             resetN;
    logic             requestTime;
    logic [REQ_W-1:0] slowClkRequest;
    logic             pauseTimer;
    logic             cancel;
    logic             slowClk;
    logic             busy;
    logic             tickPulse;
    logic [REQ_W-1:0] ticksRemaining;

    int n_vec;
    int n_err;

    game_slow_timer #(
        .TICK_DIV(TICK_DIV),
        .REQ_W   (REQ_W)
    ) dut (
        .clk           (clk),
        .resetN        (resetN),
        .requestTime   (requestTime),
        .slowClkRequest(slowClkRequest),
        .pauseTimer    (pauseTimer),
        .cancel        (cancel),
        .slowClk       (slowClk),
        .busy          (busy),
        .tickPulse     (tickPulse),
        .ticksRemaining(ticksRemaining)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past one rising edge and settle before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        resetN = 1'b0; requestTime = 1'b0; slowClkRequest = '0;
        pauseTimer = 1'b0; cancel = 1'b0;
        #23;
        n_vec++;
        if ({slowClk, busy, tickPulse} !== 3'b000 || ticksRemaining !== 11'd0) begin
            n_err++;
            $display("FAIL reset outs got s=%b b=%b t=%b r=%0d want all 0",
                     slowClk, busy, tickPulse, ticksRemaining);
        end
        resetN = 1'b1;
        step(); step();
        n_vec++;
        if ({slowClk, busy, tickPulse} !== 3'b000 || ticksRemaining !== 11'd0) begin
            n_err++;
            $display("FAIL idle_after_reset got s=%b b=%b t=%b r=%0d want all 0",
                     slowClk, busy, tickPulse, ticksRemaining);
        end
    endtask

    // R=3: ticks at E0+4,+8,+12; slowClk in the cycle after E0+12.
    task automatic test_basic();
        int exp_rem;
        logic exp_s, exp_b, exp_t;
        requestTime = 1'b1; slowClkRequest = 11'd3;
        step();
        requestTime = 1'b0;
        n_vec++;
        if (busy !== 1'b1 || ticksRemaining !== 11'd3 || slowClk !== 1'b0) begin
            n_err++;
            $display("FAIL basic.load got b=%b r=%0d s=%b want b=1 r=3 s=0",
                     busy, ticksRemaining, slowClk);
        end
        for (int k = 1; k <= 14; k++) begin
            step();
            exp_rem = (k >= 12) ? 0 : 3 - k / 4;
            exp_t   = (k % 4 == 0) && (k <= 12);
            exp_s   = (k == 12);
            exp_b   = (k < 12);
            n_vec++;
            if (slowClk !== exp_s || busy !== exp_b || tickPulse !== exp_t ||
                ticksRemaining !== 11'(exp_rem)) begin
                n_err++;
                $display("FAIL basic k=%0d got s=%b b=%b t=%b r=%0d want s=%b b=%b t=%b r=%0d",
                         k, slowClk, busy, tickPulse, ticksRemaining,
                         exp_s, exp_b, exp_t, exp_rem);
            end
        end
    endtask

    task automatic test_zero();
        requestTime = 1'b1; slowClkRequest = 11'd0;
        step();
        requestTime = 1'b0;
        n_vec++;
        if (slowClk !== 1'b1 || busy !== 1'b0 || ticksRemaining !== 11'd0) begin
            n_err++;
            $display("FAIL zero.pulse got s=%b b=%b r=%0d want s=1 b=0 r=0",
                     slowClk, busy, ticksRemaining);
        end
        step();
        n_vec++;
        if (slowClk !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL zero.after got s=%b b=%b want s=0 b=0", slowClk, busy);
        end
    endtask

    // R=3 with pause over edges E0+5..E0+9: expiry slips 5 cycles to E0+17.
    task automatic test_pause();
        int a;
        int exp_rem;
        logic paused, exp_s, exp_b, exp_t;
        requestTime = 1'b1; slowClkRequest = 11'd3;
        step();
        requestTime = 1'b0;
        a = 0;
        for (int k = 1; k <= 18; k++) begin
            paused = (k >= 5) && (k <= 9);
            pauseTimer = paused;
            step();
            if (!paused) a++;
            exp_rem = (a >= 12) ? 0 : 3 - a / 4;
            exp_t   = !paused && (a % 4 == 0) && (a <= 12);
            exp_s   = !paused && (a == 12);
            exp_b   = (a < 12);
            n_vec++;
            if (slowClk !== exp_s || busy !== exp_b || tickPulse !== exp_t ||
                ticksRemaining !== 11'(exp_rem)) begin
                n_err++;
                $display("FAIL pause k=%0d got s=%b b=%b t=%b r=%0d want s=%b b=%b t=%b r=%0d",
                         k, slowClk, busy, tickPulse, ticksRemaining,
                         exp_s, exp_b, exp_t, exp_rem);
            end
        end
        pauseTimer = 1'b0;
    endtask

    // R=5 then retrigger R=2 at E0+7: expiry at E0+15, one pulse total.
    task automatic test_retrigger();
        int pulses;
        int exp_rem;
        logic exp_s, exp_t;
        requestTime = 1'b1; slowClkRequest = 11'd5;
        step();
        requestTime = 1'b0;
        pulses = 0;
        for (int k = 1; k <= 20; k++) begin
            if (k == 7) begin
                requestTime = 1'b1; slowClkRequest = 11'd2;
            end
            step();
            requestTime = 1'b0;
            if (slowClk === 1'b1) pulses++;
            if (k < 7) exp_rem = 5 - k / 4;
            else if (k < 15) exp_rem = 2 - (k - 7) / 4;
            else exp_rem = 0;
            exp_t = (k == 4) || ((k > 7) && ((k - 7) % 4 == 0) && (k <= 15));
            exp_s = (k == 15);
            n_vec++;
            if (slowClk !== exp_s || tickPulse !== exp_t ||
                ticksRemaining !== 11'(exp_rem)) begin
                n_err++;
                $display("FAIL retrig k=%0d got s=%b t=%b r=%0d want s=%b t=%b r=%0d",
                         k, slowClk, tickPulse, ticksRemaining, exp_s, exp_t, exp_rem);
            end
        end
        n_vec++;
        if (pulses != 1) begin
            n_err++;
            $display("FAIL retrig.count got %0d pulses want 1", pulses);
        end
    endtask

    task automatic test_cancel();
        int pulses;
        requestTime = 1'b1; slowClkRequest = 11'd4;
        step();
        requestTime = 1'b0;
        for (int k = 1; k <= 5; k++) step();
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        n_vec++;
        if (busy !== 1'b0 || ticksRemaining !== 11'd0 || slowClk !== 1'b0) begin
            n_err++;
            $display("FAIL cancel.idle got b=%b r=%0d s=%b want b=0 r=0 s=0",
                     busy, ticksRemaining, slowClk);
        end
        pulses = 0;
        for (int k = 0; k < 24; k++) begin
            step();
            if (slowClk !== 1'b0 || busy !== 1'b0) pulses++;
        end
        n_vec++;
        if (pulses != 0) begin
            n_err++;
            $display("FAIL cancel.quiet got %0d active cycles want 0", pulses);
        end
        // cancel and retrigger on the same edge while running: cancel wins.
        requestTime = 1'b1; slowClkRequest = 11'd4;
        step();
        step();
        cancel = 1'b1; requestTime = 1'b1; slowClkRequest = 11'd7;
        step();
        cancel = 1'b0; requestTime = 1'b0;
        n_vec++;
        if (busy !== 1'b0 || ticksRemaining !== 11'd0 || slowClk !== 1'b0) begin
            n_err++;
            $display("FAIL cancel_vs_req got b=%b r=%0d s=%b want b=0 r=0 s=0",
                     busy, ticksRemaining, slowClk);
        end
    endtask

    task automatic test_async_reset();
        int bad;
        requestTime = 1'b1; slowClkRequest = 11'd120;
        step();
        requestTime = 1'b0;
        for (int k = 0; k < 12; k++) step();
        n_vec++;
        if (busy !== 1'b1 || ticksRemaining !== 11'd117) begin
            n_err++;
            $display("FAIL areset.pre got b=%b r=%0d want b=1 r=117", busy, ticksRemaining);
        end
        #2 resetN = 1'b0;
        #1;
        n_vec++;
        if ({slowClk, busy, tickPulse} !== 3'b000 || ticksRemaining !== 11'd0) begin
            n_err++;
            $display("FAIL areset.async got s=%b b=%b t=%b r=%0d want all 0",
                     slowClk, busy, tickPulse, ticksRemaining);
        end
        step(); step();
        resetN = 1'b1;
        bad = 0;
        for (int k = 0; k < 520; k++) begin
            step();
            if (slowClk !== 1'b0 || busy !== 1'b0) bad++;
        end
        n_vec++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL areset.quiet got %0d active cycles want 0", bad);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_basic();
        step();
        test_zero();
        step();
        test_pause();
        step();
        test_retrigger();
        step();
        test_cancel();
        step();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
